// File: rtl/i2c_init_sequencer.sv
// Walks a parameter table of bytes, issuing one single-byte I2C write per entry.
// Optional watchdog on controller stalls: define I2C_SEQ_TIMEOUT_EN.
module i2c_init_sequencer #(
  parameter int                    NUM_WRITES     = 4,
  parameter logic [NUM_WRITES*8-1:0] TABLE        = 32'hA5_3C_81_07,
  parameter logic [6:0]            PERIPH_ADDR    = 7'h1A,
  parameter int                    GAP_CYCLES     = 8,
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       ctrl_ready,
  output logic       ctrl_enable,
  output logic       ctrl_mode,
  output logic [6:0] ctrl_addr,
  output logic [7:0] ctrl_byte,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] index
);

  typedef enum logic [2:0] {
    IDLE, REQUEST, ACTIVE, GAP, DONE, FAULT
  } state_t;

  localparam int            GW       = $clog2(GAP_CYCLES + 1);
  localparam logic [7:0]    LAST     = 8'(NUM_WRITES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [7:0]    ENTRY0   = TABLE[7:0];

  function automatic logic [7:0] entry(input logic [7:0] i);
    logic [NUM_WRITES*8-1:0] sh;
    sh = TABLE >> {i, 3'b000};
    return sh[7:0];
  endfunction

  state_t        state, state_d;
  logic [GW-1:0] gap_cnt, gap_cnt_d;
  logic          enable_d, busy_d, done_d, error_d;
  logic [7:0]    index_d, byte_d;
  logic          timeout;
  logic          gap_end;

  assign ctrl_mode = 1'b1;
  assign ctrl_addr = PERIPH_ADDR;
  assign gap_end   = (gap_cnt == GAP_LAST);

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
  logic          waiting;

  assign waiting = (state == REQUEST) || (state == ACTIVE);
  assign timeout = waiting && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Cleared on every state change so each wait state gets a fresh budget
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wait_cnt <= '0;
    else if (state_d != state)
      wait_cnt <= '0;
    else if (waiting)
      wait_cnt <= wait_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      ctrl_enable <= 1'b0;
      ctrl_byte   <= ENTRY0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      index       <= '0;
    end else begin
      state       <= state_d;
      gap_cnt     <= gap_cnt_d;
      ctrl_enable <= enable_d;
      ctrl_byte   <= byte_d;
      busy        <= busy_d;
      done        <= done_d;
      error       <= error_d;
      index       <= index_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE, DONE, FAULT:
        if (start) state_d = REQUEST;
      REQUEST:
        if (!ctrl_ready)  state_d = ACTIVE;
        else if (timeout) state_d = FAULT;
      ACTIVE:
        if (ctrl_ready)   state_d = GAP;
        else if (timeout) state_d = FAULT;
      GAP:
        if (gap_end)
          state_d = (index == LAST) ? DONE : REQUEST;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    enable_d  = ctrl_enable;
    busy_d    = busy;
    done_d    = done;
    error_d   = error;
    index_d   = index;
    byte_d    = ctrl_byte;
    gap_cnt_d = gap_cnt;
    unique case (state)
      IDLE, DONE, FAULT:
        if (start) begin
          enable_d = 1'b1;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          error_d  = 1'b0;
          index_d  = '0;
          byte_d   = ENTRY0;
        end
      // Drop enable on the first low ready: one transaction per entry
      REQUEST:
        if (!ctrl_ready) begin
          enable_d = 1'b0;
        end else if (timeout) begin
          enable_d = 1'b0;
          busy_d   = 1'b0;
          error_d  = 1'b1;
        end
      ACTIVE:
        if (ctrl_ready) begin
          gap_cnt_d = '0;
        end else if (timeout) begin
          busy_d  = 1'b0;
          error_d = 1'b1;
        end
      GAP: begin
        gap_cnt_d = gap_cnt + 1'b1;
        if (gap_end) begin
          if (index == LAST) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            index_d  = index + 8'd1;
            byte_d   = entry(index + 8'd1);
            enable_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Directed bench for i2c_init_sequencer with a behavioural controller model.
// Covers sequencing, pacing, start-while-busy, mid-run reset and stalls.
module tb_i2c_init_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       ctrl_ready = 1'b1;
  logic       ctrl_enable, ctrl_mode;
  logic [6:0] ctrl_addr;
  logic [7:0] ctrl_byte, index;
  logic       busy, done, error;

  always #5 clk = ~clk;

  i2c_init_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .ctrl_ready(ctrl_ready), .ctrl_enable(ctrl_enable),
    .ctrl_mode(ctrl_mode), .ctrl_addr(ctrl_addr),
    .ctrl_byte(ctrl_byte), .busy(busy), .done(done),
    .error(error), .index(index)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] exp_b [4] = '{8'h07, 8'h81, 8'h3C, 8'hA5};

  always @(posedge clk) cyc++;

  // Controller model: sees enable, holds ready high for hold cycles,
  // then ready low for bsy cycles (transaction), then STOP/IDLE.
  int mstate = 0, mcnt = 0, hold = 3, bsy = 5;
  bit stuck = 0;
  int ntx = 0, en_viol = 0, hold_viol = 0, addr_bad = 0;
  int t_rdy = 0, gap_len = 0, en_len = 0;
  logic [7:0] cap[$];

  always @(negedge clk) begin
    if (reset) begin
      mstate = 0; mcnt = 0; ctrl_ready = 1'b1;
    end else begin
      case (mstate)
        0: if (ctrl_enable && !stuck) begin
          gap_len = cyc - t_rdy;
          en_len = 1; mcnt = 0; mstate = 1;
        end
        1: begin
          if (ctrl_enable) en_len++;
          else hold_viol++;
          mcnt++;
          if (mcnt >= hold) begin
            ctrl_ready = 1'b0;
            cap.push_back(ctrl_byte);
            if (ctrl_addr !== 7'h1A || ctrl_mode !== 1'b1)
              addr_bad++;
            ntx++; mcnt = 0; mstate = 2;
          end
        end
        2: begin
          if (ctrl_enable) en_viol++;
          mcnt++;
          if (mcnt >= bsy) begin
            ctrl_ready = 1'b1; t_rdy = cyc;
            mcnt = 0; mstate = 3;
          end
        end
        default: begin
          if (ctrl_enable) en_viol++;
          mcnt++;
          if (mcnt >= 3) mstate = 0;
        end
      endcase
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({ctrl_enable, busy, done, error} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000",
               {ctrl_enable, busy, done, error});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (index !== 8'd0 || ctrl_byte !== 8'h07) begin
      errors++;
      $display("FAIL reset_idx_byte got=%0d/%h exp=0/07",
               index, ctrl_byte);
    end
    checks++;
    if (ctrl_mode !== 1'b1 || ctrl_addr !== 7'h1A) begin
      errors++;
      $display("FAIL reset_mode_addr got=%b/%h exp=1/1a",
               ctrl_mode, ctrl_addr);
    end
  endtask

  task automatic test_sequence();
    int done_cyc;
    hold = 3; cap.delete(); ntx = 0;
    en_viol = 0; hold_viol = 0; addr_bad = 0;
    pulse_start();
    checks++;
    if (ctrl_enable !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_resp en=%b busy=%b exp=1/1",
               ctrl_enable, busy);
    end
    for (int i = 0; i < 500 && !done; i++) @(negedge clk);
    done_cyc = cyc;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL seq_done timeout done=%b exp=1", done);
    end
    checks++;
    if (cap.size() != 4) begin
      errors++;
      $display("FAIL seq_count got=%0d exp=4", cap.size());
    end
    for (int i = 0; i < 4 && i < cap.size(); i++) begin
      checks++;
      if (cap[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL seq_byte%0d got=%h exp=%h",
                 i, cap[i], exp_b[i]);
      end
    end
    checks++;
    if (index !== 8'd3 || busy !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL seq_final idx=%0d busy=%b err=%b exp=3/0/0",
               index, busy, error);
    end
    checks++;
    if (en_viol != 0 || hold_viol != 0 || addr_bad != 0) begin
      errors++;
      $display("FAIL seq_proto en=%0d hold=%0d addr=%0d exp=0/0/0",
               en_viol, hold_viol, addr_bad);
    end
    checks++;
    if (gap_len != 9) begin
      errors++;
      $display("FAIL gap_timing got=%0d exp=9", gap_len);
    end
    checks++;
    if (done_cyc - t_rdy != 9) begin
      errors++;
      $display("FAIL done_timing got=%0d exp=9", done_cyc - t_rdy);
    end
  endtask

  task automatic test_long_hold();
    hold = 20; cap.delete(); ntx = 0;
    en_viol = 0; hold_viol = 0;
    pulse_start();
    checks++;
    if (done !== 1'b0 || index !== 8'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart done=%b idx=%0d busy=%b exp=0/0/1",
               done, index, busy);
    end
    for (int i = 0; i < 800 && !done; i++) @(negedge clk);
    checks++;
    if (done !== 1'b1 || cap.size() != 4) begin
      errors++;
      $display("FAIL hold_done done=%b n=%0d exp=1/4",
               done, cap.size());
    end
    checks++;
    if (en_len != 21) begin
      errors++;
      $display("FAIL hold_en_len got=%0d exp=21", en_len);
    end
    checks++;
    if (en_viol != 0 || hold_viol != 0) begin
      errors++;
      $display("FAIL hold_proto en=%0d hold=%0d exp=0/0",
               en_viol, hold_viol);
    end
    hold = 3;
  endtask

  task automatic test_back_to_back();
    cap.delete(); ntx = 0; en_viol = 0;
    pulse_start();
    for (int i = 0; i < 300 && !(ntx == 2 && mstate == 2); i++)
      @(negedge clk);
    checks++;
    if (!(ntx == 2 && mstate == 2)) begin
      errors++;
      $display("FAIL b2b_reach ntx=%0d st=%0d exp=2/2", ntx, mstate);
    end
    pulse_start();
    for (int i = 0; i < 500 && !done; i++) @(negedge clk);
    checks++;
    if (done !== 1'b1 || cap.size() != 4 || en_viol != 0) begin
      errors++;
      $display("FAIL b2b_count done=%b n=%0d viol=%0d exp=1/4/0",
               done, cap.size(), en_viol);
    end
    checks++;
    if (cap.size() == 4 && (cap[2] !== 8'h3C || cap[3] !== 8'hA5)) begin
      errors++;
      $display("FAIL b2b_bytes got=%h,%h exp=3c,a5", cap[2], cap[3]);
    end
  endtask

  task automatic test_reset_mid();
    cap.delete(); ntx = 0;
    pulse_start();
    for (int i = 0; i < 300 && !(ntx == 3 && mstate == 3); i++)
      @(negedge clk);
    checks++;
    if (!(ntx == 3 && mstate == 3) || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_reach ntx=%0d busy=%b exp=3/1", ntx, busy);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ctrl_enable, busy, done, error} !== 4'b0 ||
        index !== 8'd0 || ctrl_byte !== 8'h07) begin
      errors++;
      $display("FAIL rst_mid en=%b busy=%b idx=%0d byte=%h exp=0/0/0/07",
               ctrl_enable, busy, index, ctrl_byte);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cap.delete(); ntx = 0;
    pulse_start();
    for (int i = 0; i < 500 && !done; i++) @(negedge clk);
    checks++;
    if (cap.size() != 4 || done !== 1'b1) begin
      errors++;
      $display("FAIL rst_rerun n=%0d done=%b exp=4/1",
               cap.size(), done);
    end
    checks++;
    if (cap.size() > 0 && cap[0] !== 8'h07) begin
      errors++;
      $display("FAIL rst_first got=%h exp=07", cap[0]);
    end
  endtask

  task automatic test_stuck();
    stuck = 1;
    pulse_start();
`ifdef I2C_SEQ_TIMEOUT_EN
    repeat (15) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || error !== 1'b0 || ctrl_enable !== 1'b1) begin
      errors++;
      $display("FAIL to_early busy=%b err=%b en=%b exp=1/0/1",
               busy, error, ctrl_enable);
    end
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 ||
        ctrl_enable !== 1'b0 || index !== 8'd0) begin
      errors++;
      $display("FAIL to_fault err=%b busy=%b en=%b idx=%0d exp=1/0/0/0",
               error, busy, ctrl_enable, index);
    end
    stuck = 0;
    pulse_start();
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL to_clear err=%b busy=%b exp=0/1", error, busy);
    end
`else
    repeat (2000) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || ctrl_enable !== 1'b1 ||
        error !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL stuck_wait busy=%b en=%b err=%b done=%b exp=1/1/0/0",
               busy, ctrl_enable, error, done);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    stuck = 0;
    pulse_start();
`endif
    for (int i = 0; i < 500 && !done; i++) @(negedge clk);
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL stuck_recover done=%b err=%b exp=1/0", done, error);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_long_hold();
    test_back_to_back();
    test_reset_mid();
    test_stuck();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
